sprite_frame_engine: RTL and testbench

- Parametrised frame-render sequencer for the 160x120 VGA game path.
- Sits between the object controllers (bird/wall position logic) and vga_adapter, and replaces the fixed bird/wall datapath.
- Per frame, for each of NUM_OBJ rectangular objects it erases the previous-frame rectangle in background colour, draws the new rectangle, then tests object 0 (player) against every other object for overlap.
- Emits one pixel per cycle on a plot/x/y/colour interface and reports done and collision.

---
 rtl/sfe_pkg.sv | 29 ++
 rtl/rect_scanner.sv | 59 +++++
 rtl/sprite_frame_engine.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_sprite_frame_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfe_pkg.sv
// rtl/sfe_pkg.sv - shared types, screen defaults and packed-field helper
// Used by sprite_frame_engine and rect_scanner.
package sfe_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ERASE,
    S_DRAW,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int          DEF_SCREEN_W  = 160;
  localparam int          DEF_SCREEN_H  = 120;
  localparam logic [2:0]  DEF_BG_COLOUR = 3'b000;

  localparam int FIELD_MAX = 16;
  localparam int VEC_MAX   = 128;

  // Field idx of a packed per-object vector; callers zero-extend into VEC_MAX and size-cast the result.
  function automatic logic [FIELD_MAX-1:0] get_field(input logic [VEC_MAX-1:0] vec,
                                                      input int idx, input int width);
    logic [VEC_MAX-1:0] mask;
    mask = (VEC_MAX'(1) << width) - VEC_MAX'(1);
    return FIELD_MAX'((vec >> (idx * width)) & mask);
  endfunction

endpackage

// File: rtl/rect_scanner.sv
// rtl/rect_scanner.sv - raster walk over one rectangle, one pixel per step
// Counters wrap to zero after the last pixel so the next rectangle starts clean.
module rect_scanner
  import sfe_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  input  logic [X_W-1:0] rect_x,
  input  logic [Y_W-1:0] rect_y,
  input  logic [X_W-1:0] rect_w,
  input  logic [Y_W-1:0] rect_h,
  output logic [X_W:0]   pix_x,
  output logic [Y_W:0]   pix_y,
  output logic           on_screen,
  output logic           last_pixel
);

  logic [X_W-1:0] px_q, px_d;
  logic [Y_W-1:0] py_q, py_d;
  logic           end_of_row;

  always_comb begin
    end_of_row = (px_q == rect_w - X_W'(1));
    last_pixel = end_of_row && (py_q == rect_h - Y_W'(1));
    pix_x      = {1'b0, rect_x} + {1'b0, px_q};
    pix_y      = {1'b0, rect_y} + {1'b0, py_q};
    on_screen  = (pix_x < (X_W+1)'(SCREEN_W)) && (pix_y < (Y_W+1)'(SCREEN_H));
    px_d       = px_q;
    py_d       = py_q;
    if (step) begin
      if (last_pixel) begin
        px_d = '0;
        py_d = '0;
      end else if (end_of_row) begin
        px_d = '0;
        py_d = py_q + Y_W'(1);
      end else begin
        px_d = px_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

endmodule

// File: rtl/sprite_frame_engine.sv
// rtl/sprite_frame_engine.sv - per-frame erase/draw/collision sequencer for the VGA path
// Erases last frame's rectangles, draws the new ones, then tests object 0 against the rest.
module sprite_frame_engine
  import sfe_pkg::*;
#(
  parameter int                  NUM_OBJ   = 4,
  parameter int                  X_W       = 8,
  parameter int                  Y_W       = 7,
  parameter int                  COLOUR_W  = 3,
  parameter int                  SCREEN_W  = DEF_SCREEN_W,
  parameter int                  SCREEN_H  = DEF_SCREEN_H,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(DEF_BG_COLOUR)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_OBJ-1:0]           obj_en,
  input  logic [NUM_OBJ*X_W-1:0]       obj_x,
  input  logic [NUM_OBJ*Y_W-1:0]       obj_y,
  input  logic [NUM_OBJ*X_W-1:0]       obj_w,
  input  logic [NUM_OBJ*Y_W-1:0]       obj_h,
  input  logic [NUM_OBJ*COLOUR_W-1:0]  obj_colour,
  output logic [X_W-1:0]               x_out,
  output logic [Y_W-1:0]               y_out,
  output logic [COLOUR_W-1:0]          colour_out,
  output logic                         plot,
  output logic                         busy,
  output logic                         done,
  output logic                         collision
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_OBJ-1:0]          cur_en_q, cur_en_d, shd_en_q, shd_en_d;
  logic [NUM_OBJ*X_W-1:0]      cur_x_q, cur_x_d, shd_x_q, shd_x_d;
  logic [NUM_OBJ*X_W-1:0]      cur_w_q, cur_w_d, shd_w_q, shd_w_d;
  logic [NUM_OBJ*Y_W-1:0]      cur_y_q, cur_y_d, shd_y_q, shd_y_d;
  logic [NUM_OBJ*Y_W-1:0]      cur_h_q, cur_h_d, shd_h_q, shd_h_d;
  logic [NUM_OBJ*COLOUR_W-1:0] cur_c_q, cur_c_d, shd_c_q, shd_c_d;
  logic                        prev_valid_q, prev_valid_d;
  logic                        collision_q, collision_d;
  logic                        plot_q, plot_d;
  logic                        done_q, done_d;
  logic [X_W-1:0]              x_q, x_d;
  logic [Y_W-1:0]              y_q, y_d;
  logic [COLOUR_W-1:0]         colour_q, colour_d;

  logic                        in_erase, scanning, step;
  logic [X_W-1:0]              src_x, src_w;
  logic [Y_W-1:0]              src_y, src_h;
  logic [COLOUR_W-1:0]         src_c;
  logic [X_W:0]                pix_x;
  logic [Y_W:0]                pix_y;
  logic                        on_screen, last_pixel;
  logic [NUM_OBJ-1:0]          cur_vld, shd_vld;
  logic                        cur_first_ok, cur_next_ok, shd_first_ok, shd_next_ok;
  logic [IDX_W-1:0]            cur_first, cur_next, shd_first, shd_next;
  logic                        hit;

  // One scanner serves both passes; only its source registers change.
  always_comb begin
    in_erase = (state_q == S_ERASE);
    src_x = X_W'(get_field(VEC_MAX'(in_erase ? shd_x_q : cur_x_q), int'(idx_q), X_W));
    src_w = X_W'(get_field(VEC_MAX'(in_erase ? shd_w_q : cur_w_q), int'(idx_q), X_W));
    src_y = Y_W'(get_field(VEC_MAX'(in_erase ? shd_y_q : cur_y_q), int'(idx_q), Y_W));
    src_h = Y_W'(get_field(VEC_MAX'(in_erase ? shd_h_q : cur_h_q), int'(idx_q), Y_W));
    src_c = COLOUR_W'(get_field(VEC_MAX'(cur_c_q), int'(idx_q), COLOUR_W));
  end

  rect_scanner #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .rect_x     (src_x),
    .rect_y     (src_y),
    .rect_w     (src_w),
    .rect_h     (src_h),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .on_screen  (on_screen),
    .last_pixel (last_pixel)
  );

  // Disabled or zero-size objects are skipped by jumping straight to the next drawable index.
  always_comb begin
    cur_vld      = '0;
    shd_vld      = '0;
    cur_first_ok = 1'b0;
    cur_next_ok  = 1'b0;
    shd_first_ok = 1'b0;
    shd_next_ok  = 1'b0;
    cur_first    = '0;
    cur_next     = '0;
    shd_first    = '0;
    shd_next     = '0;
    for (int j = 0; j < NUM_OBJ; j++) begin
      cur_vld[j] = cur_en_q[j] && (cur_w_q[j*X_W +: X_W] != '0) && (cur_h_q[j*Y_W +: Y_W] != '0);
      shd_vld[j] = prev_valid_q && shd_en_q[j] &&
                   (shd_w_q[j*X_W +: X_W] != '0) && (shd_h_q[j*Y_W +: Y_W] != '0);
    end
    for (int j = NUM_OBJ - 1; j >= 0; j--) begin
      if (cur_vld[j]) begin
        cur_first_ok = 1'b1;
        cur_first    = IDX_W'(j);
      end
      if (shd_vld[j]) begin
        shd_first_ok = 1'b1;
        shd_first    = IDX_W'(j);
      end
      if (cur_vld[j] && (j > int'(idx_q))) begin
        cur_next_ok = 1'b1;
        cur_next    = IDX_W'(j);
      end
      if (shd_vld[j] && (j > int'(idx_q))) begin
        shd_next_ok = 1'b1;
        shd_next    = IDX_W'(j);
      end
    end
    hit = cur_vld[0] && cur_vld[idx_q] &&
          ({1'b0, cur_x_q[X_W-1:0]} < {1'b0, src_x} + {1'b0, src_w}) &&
          ({1'b0, src_x} < {1'b0, cur_x_q[X_W-1:0]} + {1'b0, cur_w_q[X_W-1:0]}) &&
          ({1'b0, cur_y_q[Y_W-1:0]} < {1'b0, src_y} + {1'b0, src_h}) &&
          ({1'b0, src_y} < {1'b0, cur_y_q[Y_W-1:0]} + {1'b0, cur_h_q[Y_W-1:0]});
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cur_en_d     = cur_en_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    cur_w_d      = cur_w_q;
    cur_h_d      = cur_h_q;
    cur_c_d      = cur_c_q;
    shd_en_d     = shd_en_q;
    shd_x_d      = shd_x_q;
    shd_y_d      = shd_y_q;
    shd_w_d      = shd_w_q;
    shd_h_d      = shd_h_q;
    shd_c_d      = shd_c_q;
    prev_valid_d = prev_valid_q;
    collision_d  = collision_q;
    done_d       = 1'b0;
    scanning     = (state_q == S_ERASE) || (state_q == S_DRAW);
    step         = scanning;
    plot_d       = scanning && on_screen;
    x_d          = scanning ? pix_x[X_W-1:0] : x_q;
    y_d          = scanning ? pix_y[Y_W-1:0] : y_q;
    colour_d     = scanning ? (in_erase ? BG_COLOUR : src_c) : colour_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_en_d    = obj_en;
          cur_x_d     = obj_x;
          cur_y_d     = obj_y;
          cur_w_d     = obj_w;
          cur_h_d     = obj_h;
          cur_c_d     = obj_colour;
          collision_d = 1'b0;
          state_d     = S_LATCH;
        end
      end
      S_LATCH: begin
        if (shd_first_ok) begin
          state_d = S_ERASE;
          idx_d   = shd_first;
        end else if (cur_first_ok) begin
          state_d = S_DRAW;
          idx_d   = cur_first;
        end else begin
          state_d = S_CHECK;
          idx_d   = IDX_W'(1);
        end
      end
      S_ERASE: begin
        if (last_pixel) begin
          if (shd_next_ok) begin
            idx_d = shd_next;
          end else if (cur_first_ok) begin
            state_d = S_DRAW;
            idx_d   = cur_first;
          end else begin
            state_d = S_CHECK;
            idx_d   = IDX_W'(1);
          end
        end
      end
      S_DRAW: begin
        if (last_pixel) begin
          if (cur_next_ok) begin
            idx_d = cur_next;
          end else begin
            state_d = S_CHECK;
            idx_d   = IDX_W'(1);
          end
        end
      end
      S_CHECK: begin
        collision_d = collision_q | hit;
        if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        done_d       = 1'b1;
        shd_en_d     = cur_en_q;
        shd_x_d      = cur_x_q;
        shd_y_d      = cur_y_q;
        shd_w_d      = cur_w_q;
        shd_h_d      = cur_h_q;
        shd_c_d      = cur_c_q;
        prev_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cur_en_q     <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_w_q      <= '0;
      cur_h_q      <= '0;
      cur_c_q      <= '0;
      shd_en_q     <= '0;
      shd_x_q      <= '0;
      shd_y_q      <= '0;
      shd_w_q      <= '0;
      shd_h_q      <= '0;
      shd_c_q      <= '0;
      prev_valid_q <= 1'b0;
      collision_q  <= 1'b0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cur_en_q     <= cur_en_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      cur_w_q      <= cur_w_d;
      cur_h_q      <= cur_h_d;
      cur_c_q      <= cur_c_d;
      shd_en_q     <= shd_en_d;
      shd_x_q      <= shd_x_d;
      shd_y_q      <= shd_y_d;
      shd_w_q      <= shd_w_d;
      shd_h_q      <= shd_h_d;
      shd_c_q      <= shd_c_d;
      prev_valid_q <= prev_valid_d;
      collision_q  <= collision_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
    end
  end

  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = colour_q;
  assign plot       = plot_q;
  assign done       = done_q;
  assign collision  = collision_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_frame_engine.sv
// tb/tb_sprite_frame_engine.sv - directed self-checking bench for sprite_frame_engine
// Two objects; plotted pixels are captured on the falling edge and compared to hand-made lists.
module tb_sprite_frame_engine;

  localparam int N = 2;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] obj_en;
  logic [N*8-1:0] obj_x;
  logic [N*7-1:0] obj_y;
  logic [N*8-1:0] obj_w;
  logic [N*7-1:0] obj_h;
  logic [N*3-1:0] obj_colour;
  logic [7:0]   x_out;
  logic [6:0]   y_out;
  logic [2:0]   colour_out;
  logic         plot, busy, done, collision;

  int n_checks;
  int n_fail;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  logic coll_at_accept;
  logic busy_at_accept;
  int lat;
  int cnt;

  sprite_frame_engine #(.NUM_OBJ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .obj_en     (obj_en),
    .obj_x      (obj_x),
    .obj_y      (obj_y),
    .obj_w      (obj_w),
    .obj_h      (obj_h),
    .obj_colour (obj_colour),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (plot) got.push_back({8'd0, x_out, 1'b0, y_out, 5'd0, colour_out});
  end

  function automatic logic [31:0] pk(input int x, input int y, input int c);
    return (32'(x) << 16) | (32'(y) << 8) | 32'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_obj(input int i, input int en, input int x, input int y,
                         input int w, input int h, input int c);
    obj_en[i]          = (en != 0);
    obj_x[i*8 +: 8]    = 8'(x);
    obj_y[i*7 +: 7]    = 7'(y);
    obj_w[i*8 +: 8]    = 8'(w);
    obj_h[i*7 +: 7]    = 7'(h);
    obj_colour[i*3 +: 3] = 3'(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Latency counts the edge sampling start as 1, up to and including the edge raising done.
  task automatic run_frame(input int hold, output int latency);
    int n;
    bit seen;
    got.delete();
    start = 1'b1;
    @(posedge clk);
    n = 1;
    seen = 1'b0;
    @(negedge clk);
    coll_at_accept = collision;
    busy_at_accept = busy;
    while (!seen && n < 1000) begin
      start = (n <= hold);
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    latency = n;
    chk("frame_done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_pix(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), got[i], exp_q[i]);
    end
  endtask

  function automatic int count_colour(input int c);
    int k;
    k = 0;
    foreach (got[i]) if (got[i][2:0] == 3'(c)) k++;
    return k;
  endfunction

  initial begin
    n_checks = 0;
    n_fail = 0;
    clk = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    obj_en = '0;
    obj_x = '0;
    obj_y = '0;
    obj_w = '0;
    obj_h = '0;
    obj_colour = '0;
    do_reset();
    @(negedge clk);
    chk("rst_plot", {31'd0, plot}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_collision", {31'd0, collision}, 32'd0);
    chk("rst_x", {24'd0, x_out}, 32'd0);

    // First frame: no erase pass
    set_obj(0, 1, 10, 20, 2, 2, 5);
    set_obj(1, 0, 60, 60, 3, 3, 6);
    run_frame(0, lat);
    chk("t1_busy_at_accept", {31'd0, busy_at_accept}, 32'd1);
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_collision", {31'd0, collision}, 32'd0);
    chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
    exp_q = '{pk(10,20,5), pk(11,20,5), pk(10,21,5), pk(11,21,5)};
    check_pix("t1_pix");

    // Move down; start held for 3 cycles while busy must be ignored
    set_obj(0, 1, 10, 22, 2, 2, 5);
    run_frame(3, lat);
    chk("t2_latency", 32'(lat), 32'd12);
    exp_q = '{pk(10,20,0), pk(11,20,0), pk(10,21,0), pk(11,21,0),
              pk(10,22,5), pk(11,22,5), pk(10,23,5), pk(11,23,5)};
    check_pix("t2_pix");
    repeat (3) @(negedge clk);
    chk("t2_no_queued_start", {31'd0, busy}, 32'd0);
    chk("t2_no_extra_plots", 32'(got.size()), 32'd8);

    // Overlap, then edge-touching
    set_obj(0, 1, 40, 50, 4, 4, 2);
    set_obj(1, 1, 42, 52, 8, 8, 3);
    run_frame(0, lat);
    chk("t3a_latency", 32'(lat), 32'd88);
    chk("t3a_collision", {31'd0, collision}, 32'd1);
    chk("t3a_count", 32'(got.size()), 32'd84);
    if (got.size() == 84) begin
      chk("t3a_first", got[0], pk(10,22,0));
      chk("t3a_first_draw", got[4], pk(40,50,2));
      chk("t3a_last", got[83], pk(49,59,3));
    end
    set_obj(1, 1, 44, 50, 8, 8, 3);
    run_frame(0, lat);
    chk("t3b_coll_cleared", {31'd0, coll_at_accept}, 32'd0);
    chk("t3b_latency", 32'(lat), 32'd164);
    chk("t3b_count", 32'(got.size()), 32'd160);
    chk("t3b_collision", {31'd0, collision}, 32'd0);

    // Clipping at the bottom-right corner
    do_reset();
    set_obj(0, 1, 158, 118, 4, 4, 7);
    set_obj(1, 0, 0, 0, 1, 1, 1);
    run_frame(0, lat);
    chk("t4_latency", 32'(lat), 32'd20);
    exp_q = '{pk(158,118,7), pk(159,118,7), pk(158,119,7), pk(159,119,7)};
    check_pix("t4_pix");

    // Reset during draw after 3 pixels
    do_reset();
    set_obj(0, 1, 10, 10, 4, 4, 1);
    got.delete();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int k = 0; k < 100 && cnt < 3; k++) begin
      @(negedge clk);
      if (plot) cnt++;
    end
    chk("t5_saw_3_plots", 32'(cnt), 32'd3);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_plot_after_rst", {31'd0, plot}, 32'd0);
    chk("t5_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t5_plots_before_rst", 32'(got.size()), 32'd3);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_start_with_rst_ignored", {31'd0, busy}, 32'd0);
    set_obj(0, 1, 20, 20, 2, 2, 4);
    run_frame(0, lat);
    chk("t5_latency_no_erase", 32'(lat), 32'd8);
    exp_q = '{pk(20,20,4), pk(21,20,4), pk(20,21,4), pk(21,21,4)};
    check_pix("t5_pix");

    // Overlapping obj1 disabled, then enabled with zero width
    do_reset();
    set_obj(0, 1, 40, 50, 4, 4, 2);
    set_obj(1, 0, 42, 52, 8, 8, 3);
    run_frame(0, lat);
    chk("t6a_latency", 32'(lat), 32'd20);
    chk("t6a_collision", {31'd0, collision}, 32'd0);
    chk("t6a_count", 32'(got.size()), 32'd16);
    chk("t6a_obj1_pixels", 32'(count_colour(3)), 32'd0);
    set_obj(1, 1, 42, 52, 0, 8, 3);
    run_frame(0, lat);
    chk("t6b_latency", 32'(lat), 32'd36);
    chk("t6b_collision", {31'd0, collision}, 32'd0);
    chk("t6b_count", 32'(got.size()), 32'd32);
    chk("t6b_obj1_pixels", 32'(count_colour(3)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
